tlc_param_fsm: RTL and testbench
================================

Name: tlc_param_fsm

Overview:
Parametrised two-way traffic-light controller; next generation of the lab's manual 4-state FSM.
- Adds a timed auto mode, configurable green/yellow/all-red durations and an all-red clearance phase.
- Keeps the manual switch mode, and exports a per-phase countdown for the 7-seg/GPIO display path.
- Sits between the 1 Hz tick generator and the LED/hex driver logic on the DE2 breadboard design.

Parameters:
GREEN_SEC, 9, green duration in auto mode, in sec ticks (>=1)
YELLOW_SEC, 3, yellow duration in sec ticks (>=1)
ALLRED_SEC, 1, all-red clearance duration in sec ticks (>=1)
CNT_W, 4, countdown width; must hold max(GREEN_SEC, YELLOW_SEC, ALLRED_SEC)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
sec  in  1  one-clk-wide 1 Hz tick
auto_en  in  1  1 = timed mode, 0 = manual mode
sel  in  1  manual way request (0 = way0 green, 1 = way1 green)
night  in  1  night-flash request (used only with TLC_NIGHT_FLASH_EN)
rled0, yled0, gled0  out  1 each  way0 lamps
rled1, yled1, gled1  out  1 each  way1 lamps
cnt  out  CNT_W  remaining sec ticks of current phase
phase  out  3  current state code

Behaviour:
- Reset is synchronous and active-high on clk.
- States: G0, Y0, AR0, G1, Y1, AR1, FLASH.
- Auto cycle: G0->Y0->AR0->G1->Y1->AR1->G0.
- Reset: state=AR1, cnt=ALLRED_SEC, flash bit=0. First phase after reset is therefore G0.
- Phase entry loads cnt with that phase's duration: G=GREEN_SEC, Y=YELLOW_SEC, AR=ALLRED_SEC.
- Auto timing: on a sec tick with cnt>1, cnt decrements. On a sec tick with cnt==1, advance to the next state and load its duration in the same clk. Each phase therefore lasts exactly its duration in ticks.
- Manual mode (auto_en=0), green states:
  - cnt is held at GREEN_SEC every clk.
  - G0 with sel=1 -> Y0 on the next clk.
  - G1 with sel=0 -> Y1 on the next clk.
  - sec ticks are ignored.
- Y and AR phases are always timed, regardless of auto_en.
- auto_en 0->1 during green: countdown starts from GREEN_SEC. 1->0 during green: green holds and cnt reloads GREEN_SEC.
- sel changes during Y/AR: no effect until the next green is reached.
- Simultaneous transition and sec tick: the transition wins; the new duration is loaded with no decrement in that clk.
- Lamps are decoded combinationally from the state register (zero added latency):
  - G0: gled0, rled1
  - Y0: yled0, rled1
  - AR0/AR1: rled0, rled1
  - G1: gled1, rled0
  - Y1: yled1, rled0
- Exactly one lamp per way is lit in every non-FLASH state.
- phase codes: G0=0, Y0=1, AR0=2, G1=3, Y1=4, AR1=5, FLASH=6.
- cnt never wraps; 0 is output only in FLASH.

Optional Feature:
TLC_NIGHT_FLASH_EN
- Defined: night=1 forces FLASH on the next clk from any state, with cnt=0.
  - In FLASH, the flash bit toggles on each sec tick and drives yled0=yled1=flash bit; all other lamps are off.
  - night=0 in FLASH -> AR1 on the next clk, with cnt=ALLRED_SEC and flash bit cleared.
- Undefined: night is ignored, FLASH is unreachable, and the flash register is not built.

Decomposition:
- tlc_pkg: state enum (tlc_state_t) with the phase codes above, and the lamp-pattern constants.
- One sub-module, tlc_sec_timer: a loadable CNT_W down-counter with load, load value, sec enable, hold, and a done (cnt==1 & sec) output.

Test Plan:
1. GREEN=5, YELLOW=2, ALLRED=1, auto_en=1, tick every 4 clk -> after reset AR1/cnt=1. Sequence G0(5 ticks), Y0(2), AR0(1), G1(5), Y1(2), AR1(1); 16 ticks per cycle, cnt 5,4,3,2,1 in G0.
2. auto_en=0, sel=0 for 20 ticks -> stays G0, cnt=5. sel=1 -> Y0 next clk with cnt=2, AR0 after 2 ticks, then G1 held until sel=0.
3. Force sel edge and sec in the same clk during manual G0 -> Y0 with cnt=2, no decrement.
4. Auto mode G0 at cnt=3, drop auto_en -> cnt=5 held; raise auto_en -> decrements from 5.
5. Assert rst mid-Y1 -> next clk AR1, cnt=1, lamps rled0=rled1=1.
6. (TLC_NIGHT_FLASH_EN) night=1 during G1 -> FLASH next clk, phase=6, yled0/yled1 toggle per tick; night=0 -> AR1, cnt=1.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared types for the parametrised traffic-light controller: state codes and lamp patterns.
package tlc_pkg;

    typedef enum logic [2:0] {
        S_G0    = 3'd0,
        S_Y0    = 3'd1,
        S_AR0   = 3'd2,
        S_G1    = 3'd3,
        S_Y1    = 3'd4,
        S_AR1   = 3'd5,
        S_FLASH = 3'd6
    } tlc_state_t;

    // Lamp vectors are ordered {rled0, yled0, gled0, rled1, yled1, gled1}
    localparam logic [5:0] LAMP_G0  = 6'b001_100;
    localparam logic [5:0] LAMP_Y0  = 6'b010_100;
    localparam logic [5:0] LAMP_AR  = 6'b100_100;
    localparam logic [5:0] LAMP_G1  = 6'b100_001;
    localparam logic [5:0] LAMP_Y1  = 6'b100_010;
    localparam logic [5:0] LAMP_OFF = 6'b000_000;

    function automatic logic [5:0] lamp_of(input tlc_state_t s);
        case (s)
            S_G0:         return LAMP_G0;
            S_Y0:         return LAMP_Y0;
            S_AR0, S_AR1: return LAMP_AR;
            S_G1:         return LAMP_G1;
            S_Y1:         return LAMP_Y1;
            default:      return LAMP_OFF;
        endcase
    endfunction

endpackage

// File: rtl/tlc_sec_timer.sv
// Loadable per-phase down-counter driven by the 1 Hz tick; done marks the last tick of a phase.
module tlc_sec_timer #(
    parameter int               CNT_W   = 4,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             sec,
    input  logic             hold,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    // Load beats hold beats tick; the count parks at 1 rather than wrapping through 0.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= RST_VAL;
        else if (load)
            cnt <= load_val;
        else if (!hold && sec && (cnt > CNT_W'(1)))
            cnt <= cnt - CNT_W'(1);
    end

    assign done = sec && !hold && (cnt == CNT_W'(1));

endmodule

// File: rtl/tlc_param_fsm.sv
// Two-way traffic-light controller with timed/manual modes and all-red clearance.
// Optional night flash mode is built when TLC_NIGHT_FLASH_EN is defined.
module tlc_param_fsm
    import tlc_pkg::*;
#(
    parameter int GREEN_SEC  = 9,
    parameter int YELLOW_SEC = 3,
    parameter int ALLRED_SEC = 1,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sec,
    input  logic             auto_en,
    input  logic             sel,
    input  logic             night,
    output logic             rled0,
    output logic             yled0,
    output logic             gled0,
    output logic             rled1,
    output logic             yled1,
    output logic             gled1,
    output logic [CNT_W-1:0] cnt,
    output logic [2:0]       phase
);

    localparam logic [CNT_W-1:0] G_DUR  = CNT_W'(GREEN_SEC);
    localparam logic [CNT_W-1:0] Y_DUR  = CNT_W'(YELLOW_SEC);
    localparam logic [CNT_W-1:0] AR_DUR = CNT_W'(ALLRED_SEC);

    tlc_state_t       state_q, state_d;
    logic             load, hold, done, manual_green;
    logic [CNT_W-1:0] load_val;
    logic [5:0]       lamps;

    function automatic logic [CNT_W-1:0] dur_of(input tlc_state_t s);
        case (s)
            S_G0, S_G1:   return G_DUR;
            S_Y0, S_Y1:   return Y_DUR;
            S_AR0, S_AR1: return AR_DUR;
            default:      return '0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_AR1;
        else
            state_q <= state_d;
    end

    // Manual green pins the counter at GREEN_SEC by reloading it every clock.
    assign manual_green = !auto_en && ((state_q == S_G0) || (state_q == S_G1));
    assign hold         = (state_q == S_FLASH);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_G0:    if (manual_green ? sel : done) state_d = S_Y0;
            S_Y0:    if (done) state_d = S_AR0;
            S_AR0:   if (done) state_d = S_G1;
            S_G1:    if (manual_green ? !sel : done) state_d = S_Y1;
            S_Y1:    if (done) state_d = S_AR1;
            S_AR1:   if (done) state_d = S_G0;
            default: state_d = S_AR1;
        endcase
`ifdef TLC_NIGHT_FLASH_EN
        if (night)
            state_d = S_FLASH;
`endif
    end

    // Any state change loads the new phase duration, which also swallows a coincident tick.
    assign load     = (state_d != state_q) || manual_green;
    assign load_val = dur_of(state_d);

    tlc_sec_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (AR_DUR)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .sec      (sec),
        .hold     (hold),
        .cnt      (cnt),
        .done     (done)
    );

`ifdef TLC_NIGHT_FLASH_EN
    logic flash_q;

    always_ff @(posedge clk) begin
        if (rst || (state_d != S_FLASH))
            flash_q <= 1'b0;
        else if ((state_q == S_FLASH) && sec)
            flash_q <= !flash_q;
    end

    always_comb begin
        lamps = lamp_of(state_q);
        if (state_q == S_FLASH)
            lamps = {1'b0, flash_q, 2'b00, flash_q, 1'b0};
    end
`else
    logic unused_night;
    assign unused_night = night;

    always_comb lamps = lamp_of(state_q);
`endif

    assign {rled0, yled0, gled0, rled1, yled1, gled1} = lamps;
    assign phase = state_q;

endmodule

// File: tb/tb_tlc_param_fsm.sv
// Self-checking bench for tlc_param_fsm: directed table, hand sequences and a randomized run
// against a phase/remaining-ticks reference model. Night flash checks need TLC_NIGHT_FLASH_EN.
module tb_tlc_param_fsm;

    localparam int GRN = 5;
    localparam int YEL = 2;
    localparam int AR  = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0, sec = 1'b0, auto_en = 1'b0, sel = 1'b0, night = 1'b0;
    logic       rled0, yled0, gled0, rled1, yled1, gled1;
    logic [3:0] cnt;
    logic [2:0] phase;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: phase index 0..5 around the cycle (6 = flash), ticks remaining, flash bit
    int m_p   = 5;
    int m_rem = AR;
    bit m_fl  = 1'b0;

    typedef struct {
        bit rst, sec, auto_en, sel;
        int exp_phase, exp_cnt;
    } vec_t;
    vec_t tbl[$];

    tlc_param_fsm #(.GREEN_SEC(GRN), .YELLOW_SEC(YEL), .ALLRED_SEC(AR), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .sec(sec), .auto_en(auto_en), .sel(sel), .night(night),
        .rled0(rled0), .yled0(yled0), .gled0(gled0),
        .rled1(rled1), .yled1(yled1), .gled1(gled1),
        .cnt(cnt), .phase(phase)
    );

    always #5 clk = ~clk;

    function automatic int dur_of_phase(input int p);
        int d[3] = '{GRN, YEL, AR};
        return d[p % 3];
    endfunction

    // Way w is green at phase 3w, yellow at 3w+1, red otherwise; flash shows only yellows
    function automatic logic [5:0] lamps_for(input int p, input bit fl);
        logic [2:0] w[2];
        if (p == 6)
            return {1'b0, fl, 1'b0, 1'b0, fl, 1'b0};
        for (int k = 0; k < 2; k++) begin
            w[k][0] = (p == 3 * k);
            w[k][1] = (p == 3 * k + 1);
            w[k][2] = !(w[k][0] || w[k][1]);
        end
        return {w[0], w[1]};
    endfunction

    task automatic modelStep(input bit r, input bit s, input bit a, input bit sl, input bit n);
        bit green = (m_p == 0) || (m_p == 3);
        if (r) begin
            m_p = 5; m_rem = AR; m_fl = 1'b0;
        end
`ifdef TLC_NIGHT_FLASH_EN
        else if (n) begin
            if (m_p == 6 && s) m_fl = !m_fl;
            m_p = 6; m_rem = 0;
        end
        else if (m_p == 6) begin
            m_p = 5; m_rem = AR; m_fl = 1'b0;
        end
`endif
        else if (green && !a) begin
            if (sl == (m_p == 0)) begin
                m_p = m_p + 1; m_rem = YEL;
            end else
                m_rem = GRN;
        end
        else if (s) begin
            if (m_rem == 1) begin
                m_p = (m_p + 1) % 6; m_rem = dur_of_phase(m_p);
            end else
                m_rem = m_rem - 1;
        end
    endtask

    task automatic applyStimulus(input bit r, input bit s, input bit a, input bit sl, input bit n);
        rst = r; sec = s; auto_en = a; sel = sl; night = n;
        @(posedge clk);
        modelStep(r, s, a, sl, n);
        #1;
    endtask

    task automatic checkOutput(input string name, input int exp_p, input int exp_c, input bit exp_fl);
        logic [5:0] got_l, exp_l;
        got_l = {rled0, yled0, gled0, rled1, yled1, gled1};
        exp_l = lamps_for(exp_p, exp_fl);
        n_checks++;
        if (int'(phase) == exp_p && int'(cnt) == exp_c && got_l === exp_l)
            n_pass++;
        else
            $display("[TB] FAIL %s: got phase=%0d cnt=%0d lamps=%b, expected phase=%0d cnt=%0d lamps=%b",
                     name, phase, cnt, got_l, exp_p, exp_c, exp_l);
    endtask

    task automatic checkModel(input string name);
        checkOutput(name, m_p, m_rem, m_fl);
    endtask

    initial begin
        bit r_sel, r_auto, r_night;

        // Directed table: reset, manual hold, sel+tick collision, timed Y/AR, reset mid-Y1
        tbl.push_back('{1, 0, 1, 0, 5, 1});
        tbl.push_back('{0, 0, 1, 0, 5, 1});
        tbl.push_back('{0, 1, 1, 0, 0, 5});
        tbl.push_back('{0, 1, 1, 0, 0, 4});
        tbl.push_back('{0, 0, 1, 0, 0, 4});
        tbl.push_back('{0, 1, 0, 0, 0, 5});
        tbl.push_back('{0, 1, 0, 1, 1, 2});
        tbl.push_back('{0, 1, 0, 0, 1, 1});
        tbl.push_back('{0, 1, 0, 0, 2, 1});
        tbl.push_back('{0, 1, 0, 0, 3, 5});
        tbl.push_back('{0, 1, 0, 1, 3, 5});
        tbl.push_back('{0, 0, 0, 0, 4, 2});
        tbl.push_back('{0, 1, 0, 0, 4, 1});
        tbl.push_back('{1, 1, 0, 0, 5, 1});
        tbl.push_back('{0, 1, 0, 0, 0, 5});
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].rst, tbl[i].sec, tbl[i].auto_en, tbl[i].sel, 1'b0);
            checkOutput($sformatf("tbl%0d", i), tbl[i].exp_phase, tbl[i].exp_cnt, 1'b0);
        end

        // Auto cycle, one tick every 4 clocks, two full cycles
        applyStimulus(1, 0, 1, 0, 0);
        checkOutput("auto_reset", 5, 1, 0);
        for (int t = 1; t <= 32; t++) begin
            for (int c = 0; c < 4; c++) begin
                applyStimulus(0, c == 0, 1, 0, 0);
                checkModel($sformatf("auto_t%0d_c%0d", t, c));
            end
            if (t == 1)  checkOutput("auto_tick1_g0",  0, 5, 0);
            if (t == 6)  checkOutput("auto_tick6_y0",  1, 2, 0);
            if (t == 9)  checkOutput("auto_tick9_g1",  3, 5, 0);
            if (t == 16) checkOutput("auto_tick16_ar1", 5, 1, 0);
        end

        // Manual mode: 20 ticks with sel=0 keep G0 at GREEN_SEC
        applyStimulus(1, 0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        for (int t = 0; t < 20; t++)
            applyStimulus(0, 1, 0, 0, 0);
        checkOutput("manual_hold_g0", 0, 5, 0);

        // auto_en dropped at cnt=3 reloads GREEN_SEC, raised again decrements from it
        applyStimulus(1, 0, 1, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("auto_g0_cnt3", 0, 3, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("auto_drop_reload", 0, 5, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("manual_tick_ignored", 0, 5, 0);
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("auto_raise_dec", 0, 4, 0);

`ifdef TLC_NIGHT_FLASH_EN
        applyStimulus(1, 0, 1, 0, 0);
        for (int k = 0; k < 40 && m_p != 3; k++)
            applyStimulus(0, 1, 1, 0, 0);
        checkOutput("night_reach_g1", 3, 5, 0);
        applyStimulus(0, 0, 1, 0, 1);
        checkOutput("night_enter", 6, 0, 0);
        applyStimulus(0, 1, 1, 0, 1);
        checkOutput("night_tick1", 6, 0, 1);
        applyStimulus(0, 0, 1, 0, 1);
        checkOutput("night_idle", 6, 0, 1);
        applyStimulus(0, 1, 1, 0, 1);
        checkOutput("night_tick2", 6, 0, 0);
        applyStimulus(0, 1, 1, 0, 1);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("night_exit", 5, 1, 0);
`endif

        // Randomized run against the reference model
        applyStimulus(1, 0, 1, 0, 0);
        r_sel = 0; r_auto = 1; r_night = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 6)  r_sel   = !r_sel;
            if ($urandom_range(99) < 4)  r_auto  = !r_auto;
            if ($urandom_range(99) < 2)  r_night = !r_night;
            applyStimulus($urandom_range(199) == 0, $urandom_range(2) == 0, r_auto, r_sel, r_night);
            checkModel($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
